// File: rtl/binary_div_6_seq.sv
// Iterative signed restoring divider, one quotient bit per enabled clock.
// Q truncates toward zero; R takes the dividend's sign; B==0 raises dz.
module binary_div_6_seq #(
  parameter int WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  output logic signed [WIDTH:0]   Q,
  output logic signed [WIDTH-1:0] R,
  output logic                    busy,
  output logic                    done,
  output logic                    dz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_a;
  logic             r_sq;
  logic             r_sr;
  logic             r_dz;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dzo;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH:0]   w_qmag;
  logic [WIDTH:0]   w_qfix;
  logic [WIDTH-1:0] w_rfix;
  logic             w_bz;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1) unsigned.
  assign w_abs_a = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign w_abs_b = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign w_bz    = (B == '0);

  assign w_sh    = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial = w_sh - {1'b0, r_dvs};
  assign w_qbit  = ~w_trial[WIDTH];

  assign w_qmag  = {1'b0, r_dvd};
  assign w_qfix  = r_sq ? (~w_qmag + 1'b1) : w_qmag;
  assign w_rfix  = r_sr ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (en) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = w_bz ? S_FIX : S_CALC;
      S_CALC: if (r_cnt == LAST) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_a   <= '0;
      r_sq  <= 1'b0;
      r_sr  <= 1'b0;
      r_dz  <= 1'b0;
      r_q   <= '0;
      r_r   <= '0;
      r_dzo <= 1'b0;
    end else if (en) begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd <= w_abs_a;
            r_dvs <= w_abs_b;
            r_sq  <= A[WIDTH-1] ^ B[WIDTH-1];
            r_sr  <= A[WIDTH-1];
            r_rem <= '0;
            r_cnt <= '0;
            r_dz  <= w_bz;
            r_a   <= A;
          end
        end
        S_CALC: begin
          r_rem <= w_qbit ? w_trial[WIDTH-1:0] : w_sh[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_q   <= r_dz ? '0 : w_qfix;
          r_r   <= r_dz ? r_a : w_rfix;
          r_dzo <= r_dz;
        end
        default: ;
      endcase
    end
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign dz   = r_dzo;
  assign busy = (r_state == S_CALC) || (r_state == S_FIX);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_binary_div_6_seq.sv
// Directed bench for binary_div_6_seq: signs, corner quotients,
// divide-by-zero, stalls, mid-op reset and a full operand sweep.
module tb_binary_div_6_seq;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              start;
  logic signed [5:0] A;
  logic signed [5:0] B;
  logic signed [6:0] Q;
  logic signed [5:0] R;
  logic              busy;
  logic              done;
  logic              dz;

  int n_cmp = 0;
  int n_bad = 0;

  binary_div_6_seq #(.WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string t,
                     input logic signed [31:0] o,
                     input logic signed [31:0] e);
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", t, o, e);
    end
  endtask

  task automatic op(input int a, input int b, input int s, input int n,
                    output int lat, output logic b0);
    int k;
    @(negedge clk);
    A = 6'(a);
    B = 6'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = ~A;
    B = ~B;
    b0 = busy;
    k = 0;
    while (!done && k < 40) begin
      en = !(k >= s && k < s + n);
      @(negedge clk);
      k++;
    end
    en = 1'b1;
    lat = k;
    if (k >= 40) begin
      n_cmp++;
      n_bad++;
      $error("FAIL timeout: no done for %0d / %0d", a, b);
    end
  endtask

  initial begin
    int lat;
    int seen;
    logic b0;
    rst_n = 1'b0;
    en = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    #3;
    chk("rst_q", Q, 0);
    chk("rst_r", R, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", dz, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op(13, 4, -1, 0, lat, b0);
    chk("lat_13_4", lat, 7);
    chk("busy_e1", b0, 1);
    chk("busy_done", busy, 0);
    chk("q_13_4", Q, 3);
    chk("r_13_4", R, 1);
    chk("dz_13_4", dz, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("hold_q", Q, 3);

    op(-13, 4, -1, 0, lat, b0);
    chk("q_m13_4", Q, -3);
    chk("r_m13_4", R, -1);
    op(13, -4, -1, 0, lat, b0);
    chk("q_13_m4", Q, -3);
    chk("r_13_m4", R, 1);
    op(-13, -4, -1, 0, lat, b0);
    chk("q_m13_m4", Q, 3);
    chk("r_m13_m4", R, -1);

    op(-32, -1, -1, 0, lat, b0);
    chk("q_m32_m1", Q, 32);
    chk("r_m32_m1", R, 0);
    op(-32, 1, -1, 0, lat, b0);
    chk("q_m32_1", Q, -32);
    chk("r_m32_1", R, 0);

    op(5, 0, -1, 0, lat, b0);
    chk("lat_dz", lat, 1);
    chk("dz_5_0", dz, 1);
    chk("q_5_0", Q, 0);
    chk("r_5_0", R, 5);
    op(6, 3, -1, 0, lat, b0);
    chk("dz_6_3", dz, 0);
    chk("q_6_3", Q, 2);
    chk("r_6_3", R, 0);

    op(31, 3, 2, 3, lat, b0);
    chk("lat_stall", lat, 10);
    chk("q_31_3", Q, 10);
    chk("r_31_3", R, 1);

    @(negedge clk);
    A = 6'sd20;
    B = 6'sd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_q", Q, 0);
    chk("arst_r", R, 0);
    chk("arst_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("arst_nodone", seen, 0);
    rst_n = 1'b1;
    op(20, 7, -1, 0, lat, b0);
    chk("q_20_7", Q, 2);
    chk("r_20_7", R, 6);

    for (int a = -32; a < 32; a++) begin
      for (int b = -32; b < 32; b++) begin
        if (b != 0) begin
          op(a, b, -1, 0, lat, b0);
          chk("sweep_q", Q, a / b);
          chk("sweep_r", R, a % b);
          chk("sweep_id", int'(Q) * b + int'(R), a);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
